// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Counter width for a given operand width; never narrower than one bit.
  function automatic int nibble_count(input int width);
    int n;
    n = width / NIBBLE_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fa4.sv
// 4-bit ripple adder used as the single arithmetic slice.
module fa4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one fa4, one nibble per clock, LSB first,
// with valid/ready on both the operand and result sides.
//
// state | meaning
// IDLE  | ready for an operand pair
// ADD   | stepping through nibbles, carry chained through carry_q
// HOLD  | result presented until out_ready
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = nibble_count(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_chk
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  state_e state_q, state_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;
  logic out_valid_q, out_valid_d;

  logic [NIBBLE_W-1:0] fa_a, fa_b, fa_sum;
  logic fa_cout;

  assign fa_a = a_q[cnt_q];
  assign fa_b = b_q[cnt_q];

  fa4 u_fa4 (
    .A   (fa_a),
    .B   (fa_b),
    .Cin (carry_q),
    .Sum (fa_sum),
    .Cout(fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[cnt_q] = fa_sum;
        carry_d      = fa_cout;
        if (cnt_q == LAST) begin
          cout_d      = fa_cout;
          // Overflow: like-signed operands producing an opposite-signed result.
          ovf_d       = (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1]) &&
                        (fa_sum[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated with rst_n so nothing is advertised while the block is held in reset.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
